// File: rtl/ecu_gpio_slave.sv
// Avalon-MM GPIO slave: registered outputs, synchronized/debounced/polarity-corrected inputs, edge capture, level irq.
// Writes take effect on the accepting edge; read data is valid for one cycle after acceptance; waitrequest is never asserted.
module ecu_gpio_slave #(
    parameter int          IN_WIDTH        = 32,
    parameter int          OUT_WIDTH       = 32,
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] ACTIVE_LOW_MASK = 32'h0000_000F
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    input  logic [3:0]           avs_byteenable,
    output logic [31:0]          avs_readdata,
    output logic                 avs_readdatavalid,
    output logic                 avs_waitrequest,
    input  logic [IN_WIDTH-1:0]  gpio_in,
    output logic [OUT_WIDTH-1:0] gpio_out,
    output logic                 irq
);

    localparam logic [15:0]         DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [IN_WIDTH-1:0] POL     = ACTIVE_LOW_MASK[IN_WIDTH-1:0];

    localparam logic [2:0] A_DATA_IN  = 3'd0;
    localparam logic [2:0] A_DATA_OUT = 3'd1;
    localparam logic [2:0] A_SET      = 3'd2;
    localparam logic [2:0] A_CLR      = 3'd3;
    localparam logic [2:0] A_IRQ_MASK = 3'd4;
    localparam logic [2:0] A_EDGE_CAP = 3'd5;
    localparam logic [2:0] A_EDGE_SEL = 3'd6;

    logic [IN_WIDTH-1:0]  sync0_q, sync1_q;
    logic [IN_WIDTH-1:0]  db_q, db_d, db_dly_q;
    logic [15:0]          cnt_q [IN_WIDTH];
    logic [15:0]          cnt_d [IN_WIDTH];
    logic [OUT_WIDTH-1:0] data_out_q, data_out_d;
    logic [IN_WIDTH-1:0]  irq_mask_q, irq_mask_d;
    logic [IN_WIDTH-1:0]  edge_sel_q, edge_sel_d;
    logic [IN_WIDTH-1:0]  edge_cap_q, edge_cap_d;
    logic [31:0]          readdata_q, readdata_d;
    logic                 rdvalid_q;

    logic [31:0]          be_mask, wbits, rd_mux;
    logic [IN_WIDTH-1:0]  corr, evt;
    logic                 wr_out, wr_set, wr_clr, wr_mask, wr_cap, wr_sel;

    assign be_mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                      {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
    assign wbits   = avs_writedata & be_mask;

    assign wr_out  = avs_write && (avs_address == A_DATA_OUT);
    assign wr_set  = avs_write && (avs_address == A_SET);
    assign wr_clr  = avs_write && (avs_address == A_CLR);
    assign wr_mask = avs_write && (avs_address == A_IRQ_MASK);
    assign wr_cap  = avs_write && (avs_address == A_EDGE_CAP);
    assign wr_sel  = avs_write && (avs_address == A_EDGE_SEL);

    // Polarity is corrected before debounce so db is always "1 = active".
    assign corr = sync1_q ^ POL;

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < IN_WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (corr[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                db_d[i]  = ~db_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    assign evt = (db_q & ~db_dly_q) | (~db_q & db_dly_q & edge_sel_q);

    always_comb begin
        data_out_d = data_out_q;
        if (wr_out) begin
            data_out_d = (data_out_q & ~be_mask[OUT_WIDTH-1:0]) | wbits[OUT_WIDTH-1:0];
        end else if (wr_set) begin
            data_out_d = data_out_q | wbits[OUT_WIDTH-1:0];
        end else if (wr_clr) begin
            data_out_d = data_out_q & ~wbits[OUT_WIDTH-1:0];
        end
    end

    always_comb begin
        irq_mask_d = irq_mask_q;
        edge_sel_d = edge_sel_q;
        edge_cap_d = edge_cap_q;
        if (wr_mask) begin
            irq_mask_d = (irq_mask_q & ~be_mask[IN_WIDTH-1:0]) | wbits[IN_WIDTH-1:0];
        end
        if (wr_sel) begin
            edge_sel_d = (edge_sel_q & ~be_mask[IN_WIDTH-1:0]) | wbits[IN_WIDTH-1:0];
        end
        if (wr_cap) begin
            edge_cap_d = edge_cap_q & ~wbits[IN_WIDTH-1:0];
        end
        // A capture event in the same cycle as its clear must survive.
        edge_cap_d = edge_cap_d | evt;
    end

    // Mux reads current register contents, so a same-cycle write is not visible yet.
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            A_DATA_IN:  rd_mux[IN_WIDTH-1:0]  = db_q;
            A_DATA_OUT: rd_mux[OUT_WIDTH-1:0] = data_out_q;
            A_IRQ_MASK: rd_mux[IN_WIDTH-1:0]  = irq_mask_q;
            A_EDGE_CAP: rd_mux[IN_WIDTH-1:0]  = edge_cap_q;
            A_EDGE_SEL: rd_mux[IN_WIDTH-1:0]  = edge_sel_q;
            default:    rd_mux = '0;
        endcase
    end

    assign readdata_d = avs_read ? rd_mux : readdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0_q    <= POL;
            sync1_q    <= POL;
            db_q       <= '0;
            db_dly_q   <= '0;
            data_out_q <= '0;
            irq_mask_q <= '0;
            edge_sel_q <= '0;
            edge_cap_q <= '0;
            readdata_q <= '0;
            rdvalid_q  <= 1'b0;
            for (int i = 0; i < IN_WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync0_q    <= gpio_in;
            sync1_q    <= sync0_q;
            db_q       <= db_d;
            db_dly_q   <= db_q;
            data_out_q <= data_out_d;
            irq_mask_q <= irq_mask_d;
            edge_sel_q <= edge_sel_d;
            edge_cap_q <= edge_cap_d;
            readdata_q <= readdata_d;
            rdvalid_q  <= avs_read;
            for (int i = 0; i < IN_WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = rdvalid_q;
    assign avs_waitrequest   = 1'b0;
    assign gpio_out          = data_out_q;
    assign irq               = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_ecu_gpio_slave.sv
// Directed plus randomized bench for ecu_gpio_slave against a register-level model of the GPIO behaviour.
module tb_ecu_gpio_slave;

    localparam logic [31:0] ALM = 32'h0000_000F;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid, avs_waitrequest;
    logic [31:0] gpio_in, gpio_out;
    logic        irq;

    always #5 clk = ~clk;

    ecu_gpio_slave #(
        .IN_WIDTH(32), .OUT_WIDTH(32), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW_MASK(ALM)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
        .avs_waitrequest(avs_waitrequest),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: register contents as the bus should see them.
    logic [31:0] m_out, m_mask, m_sel, m_cap, m_din;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk(tag, {1'b0, obs}, {1'b0, exp});
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {32'b0, obs}, {32'b0, exp});
    endtask

    function automatic logic [31:0] bm(input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{be[i]}};
        return r;
    endfunction

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        @(negedge clk);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        chk(tag, {avs_readdatavalid, avs_readdata}, {1'b1, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d, t, g, prev;
        logic [3:0]  be;
        logic [2:0]  a;
        logic        seen;
        int          gl;

        reset_n = 1'b0; gpio_in = ALM;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; avs_byteenable = '0;
        m_out = '0; m_mask = '0; m_sel = '0; m_cap = '0; m_din = '0;

        repeat (3) @(negedge clk);
        chk32("rst_gpio_out", gpio_out, 32'h0);
        chk("rst_rdata", {avs_readdatavalid, avs_readdata}, 33'h0);
        chk1("rst_irq", irq, 1'b0);
        chk1("rst_wait", avs_waitrequest, 1'b0);
        reset_n = 1'b1;

        // Idle with inactive pins: nothing captured.
        repeat (100) @(negedge clk);
        rd("idle_din", 3'd0, 32'h0);
        rd("idle_cap", 3'd5, 32'h0);
        chk1("idle_irq", irq, 1'b0);
        chk32("idle_out", gpio_out, 32'h0);

        // Output register via partial write, SET and CLR.
        wr(3'd1, 32'hA5A5_0000, 4'b1100);
        wr(3'd2, 32'h0000_00FF, 4'b1111);
        wr(3'd3, 32'h0000_000F, 4'b1111);
        m_out = 32'hA5A5_00F0;
        chk32("out_pins", gpio_out, m_out);
        rd("out_read", 3'd1, m_out);
        @(negedge clk);
        chk1("rvalid_one_cycle", avs_readdatavalid, 1'b0);
        chk32("rdata_hold", avs_readdata, m_out);

        // Same-cycle read and write: read sees the old value.
        @(negedge clk);
        avs_address = 3'd1; avs_read = 1'b1; avs_write = 1'b1;
        avs_writedata = 32'h1234_5678; avs_byteenable = 4'b1111;
        @(negedge clk);
        avs_read = 1'b0; avs_write = 1'b0;
        chk("rw_same_cycle", {avs_readdatavalid, avs_readdata}, {1'b1, m_out});
        m_out = 32'h1234_5678;
        chk32("rw_pins", gpio_out, m_out);

        // Press bit0: DATA_IN flips at edge k+5, capture and irq at edge k+6.
        wr(3'd4, 32'h1, 4'b1111); m_mask = 32'h1;
        @(negedge clk); gpio_in = ALM & ~32'h1;
        repeat (5) @(negedge clk);
        avs_address = 3'd0; avs_read = 1'b1;
        @(negedge clk);
        chk("press_din_k5", {avs_readdatavalid, avs_readdata}, {1'b1, 32'h0});
        chk1("press_irq_k5", irq, 1'b0);
        @(negedge clk);
        chk("press_din_k6", {avs_readdatavalid, avs_readdata}, {1'b1, 32'h1});
        chk1("press_irq_k6", irq, 1'b1);
        avs_address = 3'd5;
        @(negedge clk);
        avs_read = 1'b0;
        chk("press_cap", {avs_readdatavalid, avs_readdata}, {1'b1, 32'h1});
        m_din = 32'h1; m_cap = 32'h1;
        wr(3'd5, 32'h1, 4'b1111); m_cap = '0;
        chk1("w1c_irq", irq, 1'b0);
        rd("w1c_cap", 3'd5, m_cap);

        // Three-cycle glitch on bit1 is filtered.
        @(negedge clk); gpio_in = ALM & ~32'h3;
        repeat (3) @(negedge clk);
        gpio_in = ALM & ~32'h1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | irq;
        end
        chk1("glitch_irq", seen, 1'b0);
        rd("glitch_din", 3'd0, m_din);
        rd("glitch_cap", 3'd5, m_cap);

        // Release bit0 with EDGE_SEL clear: no capture.
        @(negedge clk); gpio_in = ALM;
        repeat (12) @(negedge clk);
        m_din = '0;
        rd("rel_din", 3'd0, m_din);
        rd("rel_cap", 3'd5, m_cap);

        // Bit2 both-edge capture; W1C landing on the release-capture edge loses.
        wr(3'd6, 32'h4, 4'b1111); m_sel = 32'h4;
        wr(3'd4, 32'h5, 4'b1111); m_mask = 32'h5;
        @(negedge clk); gpio_in = ALM & ~32'h4;
        repeat (12) @(negedge clk);
        m_din = 32'h4; m_cap = 32'h4;
        rd("sel_press_cap", 3'd5, m_cap);
        chk1("sel_press_irq", irq, 1'b1);
        wr(3'd5, 32'h4, 4'b1111); m_cap = '0;
        chk1("sel_clr_irq", irq, 1'b0);
        @(negedge clk); gpio_in = ALM;
        repeat (5) @(negedge clk);
        wr(3'd5, 32'h4, 4'b1111);
        m_din = '0; m_cap = 32'h4;
        chk1("evt_wins_irq", irq, 1'b1);
        rd("evt_wins_cap", 3'd5, m_cap);
        wr(3'd5, 32'h4, 4'b1111); m_cap = '0;

        // Reset with a read in flight and captures pending.
        wr(3'd4, 32'h3, 4'b1111); m_mask = 32'h3;
        @(negedge clk); gpio_in = ALM & ~32'h3;
        repeat (12) @(negedge clk);
        m_din = 32'h3; m_cap = 32'h3;
        rd("pre_rst_cap", 3'd5, m_cap);
        chk1("pre_rst_irq", irq, 1'b1);
        @(negedge clk);
        avs_address = 3'd5; avs_read = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0; avs_read = 1'b0; gpio_in = ALM;
        @(negedge clk);
        chk1("mid_rst_vld", avs_readdatavalid, 1'b0);
        chk1("mid_rst_irq", irq, 1'b0);
        chk32("mid_rst_out", gpio_out, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        m_out = '0; m_mask = '0; m_sel = '0; m_cap = '0; m_din = '0;
        @(negedge clk);
        chk1("post_rst_vld", avs_readdatavalid, 1'b0);
        repeat (12) @(negedge clk);
        rd("post_rst_cap", 3'd5, 32'h0);
        rd("post_rst_din", 3'd0, 32'h0);
        rd("post_rst_mask", 3'd4, 32'h0);

        // Randomized output-register traffic.
        for (int i = 0; i < 10; i++) begin
            a  = 3'($urandom_range(1, 3));
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            wr(a, d, be);
            case (a)
                3'd1:    m_out = (m_out & ~bm(be)) | (d & bm(be));
                3'd2:    m_out = m_out | (d & bm(be));
                default: m_out = m_out & ~(d & bm(be));
            endcase
            chk32("rand_out_pins", gpio_out, m_out);
            rd("rand_out_read", 3'd1, m_out);
        end
        rd("wo_set_reads0", 3'd2, 32'h0);
        rd("wo_clr_reads0", 3'd3, 32'h0);
        wr(3'd7, 32'hFFFF_FFFF, 4'b1111);
        rd("rsvd_reads0", 3'd7, 32'h0);
        chk32("rsvd_no_effect", gpio_out, m_out);

        // Randomized input rounds: stable changes plus sub-threshold glitches.
        for (int r = 0; r < 8; r++) begin
            d = $urandom; be = 4'($urandom_range(0, 15));
            wr(3'd6, d, be); m_sel = (m_sel & ~bm(be)) | (d & bm(be));
            d = $urandom; be = 4'($urandom_range(0, 15));
            wr(3'd4, d, be); m_mask = (m_mask & ~bm(be)) | (d & bm(be));
            t  = $urandom;
            g  = $urandom;
            gl = $urandom_range(1, 3);
            @(negedge clk); gpio_in = t ^ g;
            repeat (gl) @(negedge clk);
            gpio_in = t;
            repeat (12) @(negedge clk);
            prev  = m_din;
            m_din = t ^ ALM;
            m_cap = m_cap | (m_din & ~prev) | (prev & ~m_din & m_sel);
            rd("rand_din", 3'd0, m_din);
            rd("rand_cap", 3'd5, m_cap);
            rd("rand_mask", 3'd4, m_mask);
            rd("rand_sel", 3'd6, m_sel);
            chk1("rand_irq", irq, |(m_cap & m_mask));
            d = $urandom; be = 4'($urandom_range(0, 15));
            wr(3'd5, d, be); m_cap = m_cap & ~(d & bm(be));
            rd("rand_w1c_cap", 3'd5, m_cap);
            chk1("rand_w1c_irq", irq, |(m_cap & m_mask));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
